// File: rtl/timer_ctrl_pkg.sv
// Shared encodings and constants for the round controller.
// The optional auto-restart feature is selected by TIMER_AUTO_RESTART_EN.
package timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_e;

  localparam int ROUND_MAX                    = 15;
  localparam int BLINK_CYCLES_DEFAULT         = 25_000_000;
  localparam int AUTO_RESTART_TOGGLES_DEFAULT = 6;

  // Bits needed to hold a counter running 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_round_controller_if.sv
// Button, timer and display signals between the round controller and its surroundings.
interface timer_round_controller_if;

  logic       start_btn;
  logic       pause_btn;
  logic       expire_pulse;
  logic       timer_enable;
  logic       timer_reload;
  logic       round_active;
  logic       time_up;
  logic       display_on;
  logic [3:0] round_count;

  // Environment side: buttons and the timer's end-of-count pulse.
  modport master (
    output start_btn, pause_btn, expire_pulse,
    input  timer_enable, timer_reload, round_active, time_up, display_on, round_count
  );

  // Controller side.
  modport slave (
    input  start_btn, pause_btn, expire_pulse,
    output timer_enable, timer_reload, round_active, time_up, display_on, round_count
  );

endinterface

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw button.
// One press_pulse per press; a held button gives no repeats.
module button_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic btn_in,
  output logic press_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic press_q;

  // NOTE: non-blocking assignments make each flop sample the previous stage's old value,
  // which is what turns this chain into a shift register rather than a single wire.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      press_q <= sync2_q & ~prev_q;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/timer_round_controller.sv
// Round-sequencing FSM for the countdown timer: buttons, reload/enable, round count, expiry blink.
// Define TIMER_AUTO_RESTART_EN to restart automatically after AUTO_RESTART_TOGGLES blink toggles.
module timer_round_controller
  import timer_ctrl_pkg::*;
#(
  parameter int BLINK_CYCLES         = BLINK_CYCLES_DEFAULT,
  parameter int AUTO_RESTART_TOGGLES = AUTO_RESTART_TOGGLES_DEFAULT
) (
  input logic                     clock,
  input logic                     resetn,
  timer_round_controller_if.slave bus
);

  localparam int              BW         = cnt_width(BLINK_CYCLES);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_CYCLES - 1);

  if (BLINK_CYCLES < 1 || AUTO_RESTART_TOGGLES < 1) begin : g_bad_cfg
    $error("timer_round_controller: BLINK_CYCLES and AUTO_RESTART_TOGGLES must be >= 1");
  end

  state_e          state_q, state_d;
  logic            start_ev, pause_ev;
  logic [BW-1:0]   blink_q, blink_d;
  logic            display_q, display_d;
  logic [3:0]      round_q, round_d;
  logic            blink_wrap;
  logic            auto_restart;

  button_edge_sync u_start_sync (
    .clock      (clock),
    .resetn     (resetn),
    .btn_in     (bus.start_btn),
    .press_pulse(start_ev)
  );

  button_edge_sync u_pause_sync (
    .clock      (clock),
    .resetn     (resetn),
    .btn_in     (bus.pause_btn),
    .press_pulse(pause_ev)
  );

  assign blink_wrap = (state_q == ST_EXPIRED) && (blink_q == BLINK_LAST);

`ifdef TIMER_AUTO_RESTART_EN
  localparam int            TW          = cnt_width(AUTO_RESTART_TOGGLES);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(AUTO_RESTART_TOGGLES - 1);

  logic [TW-1:0] toggle_q, toggle_d;

  assign auto_restart = blink_wrap && (toggle_q == TOGGLE_LAST);

  always_comb begin
    toggle_d = '0;
    if (state_q == ST_EXPIRED && state_d == ST_EXPIRED && blink_wrap) begin
      toggle_d = toggle_q + 1'b1;
    end else if (state_q == ST_EXPIRED && state_d == ST_EXPIRED) begin
      toggle_d = toggle_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end
`else
  assign auto_restart = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default on the first lines,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ev) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RUN;
      ST_RUN: begin
        // Expiry wins over a pause arriving in the same cycle.
        if (bus.expire_pulse)  state_d = ST_EXPIRED;
        else if (pause_ev)     state_d = ST_PAUSE;
      end
      ST_PAUSE:   if (start_ev || pause_ev) state_d = ST_RUN;
      ST_EXPIRED: if (start_ev || auto_restart) state_d = ST_LOAD;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    round_d   = round_q;
    blink_d   = '0;
    display_d = 1'b1;

    if (state_q == ST_RUN && state_d == ST_EXPIRED && round_q != 4'(ROUND_MAX)) begin
      round_d = round_q + 4'd1;
    end

    // Entering EXPIRED (or any other state) leaves the counter cleared and the display lit.
    if (state_q == ST_EXPIRED && state_d == ST_EXPIRED) begin
      if (blink_wrap) begin
        display_d = ~display_q;
      end else begin
        blink_d   = blink_q + 1'b1;
        display_d = display_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      blink_q   <= '0;
      display_q <= 1'b1;
      round_q   <= '0;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      display_q <= display_d;
      round_q   <= round_d;
    end
  end

  assign bus.timer_enable = (state_q == ST_RUN);
  assign bus.timer_reload = (state_q == ST_LOAD);
  assign bus.round_active = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.time_up      = (state_q == ST_EXPIRED);
  assign bus.display_on   = display_q;
  assign bus.round_count  = round_q;

endmodule

// File: tb/tb_timer_round_controller.sv
// Directed bench for timer_round_controller with BLINK_CYCLES=4, AUTO_RESTART_TOGGLES=2.
// Builds with or without TIMER_AUTO_RESTART_EN.
module tb_timer_round_controller;

  // {timer_reload, timer_enable, round_active, time_up} per state
  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_LOAD  = 4'b1000;
  localparam logic [3:0] S_RUN   = 4'b0110;
  localparam logic [3:0] S_PAUSE = 4'b0010;
  localparam logic [3:0] S_EXP   = 4'b0001;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   reloads;
  logic stayed;

  timer_round_controller_if bus ();

  timer_round_controller #(
    .BLINK_CYCLES        (4),
    .AUTO_RESTART_TOGGLES(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] st();
    return {bus.timer_reload, bus.timer_enable, bus.round_active, bus.time_up};
  endfunction

  // One-cycle press; returns just after the edge where the state reacts.
  task automatic press(input logic s, input logic p);
    bus.start_btn = s;
    bus.pause_btn = p;
    tick(1);
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    tick(3);
  endtask

  initial begin
    resetn           = 1'b0;
    bus.start_btn    = 1'b0;
    bus.pause_btn    = 1'b0;
    bus.expire_pulse = 1'b0;
    tick(3);
    check("reset_state",   8'(st()),            8'(S_IDLE));
    check("reset_display", 8'(bus.display_on),  8'd1);
    check("reset_count",   8'(bus.round_count), 8'd0);
    #2 resetn = 1'b1;
    tick(1);

    bus.expire_pulse = 1'b1;
    tick(1);
    bus.expire_pulse = 1'b0;
    check("idle_expire_state", 8'(st()),            8'(S_IDLE));
    check("idle_expire_count", 8'(bus.round_count), 8'd0);

    // Held start: one reload, then RUN with no repeat.
    bus.start_btn = 1'b1;
    tick(3);
    check("start_latency_idle", 8'(st()), 8'(S_IDLE));
    tick(1);
    check("start_load", 8'(st()), 8'(S_LOAD));
    tick(1);
    check("start_run", 8'(st()), 8'(S_RUN));
    reloads = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      if (bus.timer_reload) reloads++;
    end
    check("held_no_second_reload", 8'(reloads), 8'd0);
    check("held_still_run",        8'(st()),    8'(S_RUN));
    bus.start_btn = 1'b0;
    tick(4);
    check("release_run", 8'(st()), 8'(S_RUN));

    press(1'b0, 1'b1);
    check("pause", 8'(st()), 8'(S_PAUSE));
    bus.expire_pulse = 1'b1;
    tick(1);
    bus.expire_pulse = 1'b0;
    check("pause_expire_state", 8'(st()),            8'(S_PAUSE));
    check("pause_expire_count", 8'(bus.round_count), 8'd0);
    press(1'b0, 1'b1);
    check("pause_resume", 8'(st()), 8'(S_RUN));
    press(1'b1, 1'b0);
    check("run_start_ignored", 8'(st()), 8'(S_RUN));
    press(1'b0, 1'b1);
    check("pause_again", 8'(st()), 8'(S_PAUSE));
    press(1'b1, 1'b1);
    check("pause_both_resume", 8'(st()), 8'(S_RUN));
    tick(1);
    check("pause_both_once", 8'(st()), 8'(S_RUN));

    // Pause event and expire_pulse land on the same edge.
    bus.pause_btn = 1'b1;
    tick(1);
    bus.pause_btn = 1'b0;
    tick(2);
    bus.expire_pulse = 1'b1;
    tick(1);
    bus.expire_pulse = 1'b0;
    check("expire_beats_pause", 8'(st()),            8'(S_EXP));
    check("expire_count",       8'(bus.round_count), 8'd1);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("blink_%0d", i), 8'(bus.display_on), (i < 4) ? 8'd1 : 8'd0);
      tick(1);
    end
`ifdef TIMER_AUTO_RESTART_EN
    check("auto_restart_reload", 8'(st()), 8'(S_LOAD));
    tick(1);
    check("auto_restart_run", 8'(st()), 8'(S_RUN));
`else
    check("blink_repeat", 8'(bus.display_on), 8'd1);
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.time_up) stayed = 1'b0;
      tick(1);
    end
    check("expired_persists", 8'(stayed), 8'd1);
    press(1'b1, 1'b0);
    check("expired_start_load", 8'(st()), 8'(S_LOAD));
    tick(1);
    check("expired_restart_run", 8'(st()), 8'(S_RUN));
`endif

    // Reset mid-round with a pause press in flight.
    bus.pause_btn = 1'b1;
    tick(1);
    bus.pause_btn = 1'b0;
    resetn = 1'b0;
    tick(1);
    check("rst_run_state",   8'(st()),            8'(S_IDLE));
    check("rst_run_count",   8'(bus.round_count), 8'd0);
    check("rst_run_display", 8'(bus.display_on),  8'd1);
    #2 resetn = 1'b1;
    tick(5);
    check("rst_event_discarded", 8'(st()), 8'(S_IDLE));

    for (int r = 1; r <= 17; r++) begin
      press(1'b1, 1'b0);
      tick(1);
      bus.expire_pulse = 1'b1;
      tick(1);
      bus.expire_pulse = 1'b0;
      check($sformatf("round_count_%0d", r), 8'(bus.round_count), (r > 15) ? 8'd15 : 8'(r));
    end
    check("rounds_end_expired", 8'(st()), 8'(S_EXP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
